// File: rtl/vedic_mac_pipe.sv
// Recursive unsigned Vedic multiplier: four half-width sub-products combined crosswise.
// Latency: combinational. Backpressure: none, pure logic.
// Recursion bottoms out at a 2x2 Vedic cell (or a single AND gate for 1-bit halves).
module vedic_mul #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);
    generate
        if (W == 1) begin : g_bit
            assign p = {1'b0, a & b};
        end else if (W == 2) begin : g_cell
            logic cross_lo, cross_hi, carry, top;
            assign cross_lo = a[1] & b[0];
            assign cross_hi = a[0] & b[1];
            assign carry    = cross_lo & cross_hi;
            assign top      = a[1] & b[1];
            assign p[0]     = a[0] & b[0];
            assign p[1]     = cross_lo ^ cross_hi;
            assign p[2]     = top ^ carry;
            assign p[3]     = top & carry;
        end else begin : g_rec
            localparam int H = W / 2;
            logic [W-1:0]   ll, hl, lh, hh;
            logic [2*W-1:0] mid;
            vedic_mul #(.W(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
            vedic_mul #(.W(H)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(hl));
            vedic_mul #(.W(H)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(lh));
            vedic_mul #(.W(H)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(hh));
            assign mid = (2*W)'(hl) + (2*W)'(lh);
            assign p   = {hh, ll} + (mid << H);
        end
    endgenerate
endmodule

// Pipelined unsigned Vedic multiply-accumulate with saturating, sticky-flag accumulator.
// Latency: 3 registered stages (operands, sub-products, accumulator); one beat per cycle.
// Backpressure: all stages freeze while the result stage holds an unconsumed beat.
module vedic_mac_pipe #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2*WIDTH+4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_en,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             sat
);
    localparam int H = WIDTH / 2;

    typedef struct packed {
        logic             vld;
        logic             acc_en;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_t;

    typedef struct packed {
        logic             vld;
        logic             acc_en;
        logic [WIDTH-1:0] ll;
        logic [WIDTH-1:0] hl;
        logic [WIDTH-1:0] lh;
        logic [WIDTH-1:0] hh;
    } sub_t;

    op_t              s1_q;
    sub_t             s2_q;
    logic             s3_vld;
    logic [ACC_W-1:0] acc;
    logic             sat_q;
    logic             en;
    logic             cap;

    logic [WIDTH-1:0]   ll_c, hl_c, lh_c, hh_c;
    logic [2*WIDTH-1:0] mid, prod;
    logic [ACC_W-1:0]   acc_base, acc_nxt;
    logic               sat_base, sat_nxt;
    logic [ACC_W:0]     sum;

    assign en  = !s3_vld || out_ready;
    assign cap = en && s2_q.vld;

    vedic_mul #(.W(H)) u_ll (.a(s1_q.a[H-1:0]),     .b(s1_q.b[H-1:0]),     .p(ll_c));
    vedic_mul #(.W(H)) u_hl (.a(s1_q.a[WIDTH-1:H]), .b(s1_q.b[H-1:0]),     .p(hl_c));
    vedic_mul #(.W(H)) u_lh (.a(s1_q.a[H-1:0]),     .b(s1_q.b[WIDTH-1:H]), .p(lh_c));
    vedic_mul #(.W(H)) u_hh (.a(s1_q.a[WIDTH-1:H]), .b(s1_q.b[WIDTH-1:H]), .p(hh_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (en) begin
            s1_q.vld <= in_valid;
            if (in_valid) begin
                s1_q.acc_en <= acc_en;
                s1_q.a      <= a;
                s1_q.b      <= b;
            end
            s2_q.vld <= s1_q.vld;
            if (s1_q.vld) begin
                s2_q.acc_en <= s1_q.acc_en;
                s2_q.ll     <= ll_c;
                s2_q.hl     <= hl_c;
                s2_q.lh     <= lh_c;
                s2_q.hh     <= hh_c;
            end
        end
    end

    assign mid  = (2*WIDTH)'(s2_q.hl) + (2*WIDTH)'(s2_q.lh);
    assign prod = {s2_q.hh, s2_q.ll} + (mid << H);

    // A clear coinciding with a capture wipes the old value before the beat lands.
    assign acc_base = clr ? '0 : acc;
    assign sat_base = clr ? 1'b0 : sat_q;
    assign sum      = {1'b0, acc_base} + (ACC_W+1)'(prod);

    always_comb begin
        acc_nxt = ACC_W'(prod);
        sat_nxt = sat_base;
        if (s2_q.acc_en) begin
            if (sum[ACC_W]) begin
                acc_nxt = '1;
                sat_nxt = 1'b1;
            end else begin
                acc_nxt = sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld <= 1'b0;
            acc    <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (en) s3_vld <= s2_q.vld;
            if (cap) begin
                acc   <= acc_nxt;
                sat_q <= sat_nxt;
            end else if (clr) begin
                acc   <= '0;
                sat_q <= 1'b0;
            end
        end
    end

    assign in_ready  = en;
    assign out_valid = s3_vld;
    assign out_data  = acc;
    assign sat       = sat_q;
endmodule

// File: tb/tb_vedic_mac_pipe.sv
// Bench for vedic_mac_pipe: directed scenarios plus randomized beats scored against an arithmetic model.
// Extra instances at WIDTH=4 (exhaustive) and WIDTH=16 (random) exercise the multiplier recursion.
module tb_vedic_mac_pipe;
    localparam longint MAXV = (64'd1 << 20) - 1;

    logic        clk, rst_n;
    logic        in_valid, in_ready, acc_en, clr, out_valid, out_ready, sat;
    logic [7:0]  a, b;
    logic [19:0] out_data;

    logic        in_valid4, in_ready4, out_valid4, sat4;
    logic [3:0]  a4, b4;
    logic [9:0]  out_data4;
    logic        in_valid16, in_ready16, out_valid16, sat16;
    logic [15:0] a16, b16;
    logic [35:0] out_data16;

    typedef struct {
        logic [19:0] data;
        logic        sat;
    } exp_t;

    exp_t   exp_q[$];
    longint q4[$];
    longint q16[$];
    longint model_acc;
    logic   model_sat;
    int     tests, fails;
    logic   last_acc, smp_in_ready, prev_stall;
    logic [19:0] prev_data;

    vedic_mac_pipe #(.WIDTH(8), .ACC_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .acc_en(acc_en), .clr(clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sat(sat));

    vedic_mac_pipe #(.WIDTH(4), .ACC_W(10)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .acc_en(1'b0), .clr(1'b0), .out_valid(out_valid4),
        .out_ready(1'b1), .out_data(out_data4), .sat(sat4));

    vedic_mac_pipe #(.WIDTH(16), .ACC_W(36)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .acc_en(1'b0), .clr(1'b0), .out_valid(out_valid16),
        .out_ready(1'b1), .out_data(out_data16), .sat(sat16));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_push(input logic [7:0] pa, input logic [7:0] pb, input logic pe);
        exp_t   e;
        longint p;
        p = longint'(pa) * longint'(pb);
        if (!pe) model_acc = p;
        else if (model_acc + p > MAXV) begin
            model_acc = MAXV;
            model_sat = 1'b1;
        end else model_acc = model_acc + p;
        e.data = 20'(model_acc);
        e.sat  = model_sat;
        exp_q.push_back(e);
    endtask

    // One clock: sample outputs at the falling edge, score any consumed result, return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        last_acc     = in_valid && in_ready;
        smp_in_ready = in_ready;
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_sat", sat, e.sat);
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        @(posedge clk);
        #1;
        if (last_acc) model_push(a, b, acc_en);
    endtask

    task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic se);
        int n;
        n = 0;
        a = sa; b = sb; acc_en = se; in_valid = 1'b1;
        do begin
            step();
            n++;
            if (!last_acc) out_ready = 1'b1;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("send_timeout", smp_in_ready, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_acc = 0;
        model_sat = 1'b0;
    endtask

    initial begin
        logic [7:0] ca[4];
        logic [7:0] cb[4];
        tests = 0; fails = 0;
        model_acc = 0; model_sat = 1'b0;
        prev_stall = 1'b0; prev_data = '0; last_acc = 1'b0; smp_in_ready = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; acc_en = 1'b0; clr = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; in_valid16 = 1'b0; a16 = '0; b16 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat", sat, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // 1: single beat latency and value
        out_ready = 1'b1;
        send(8'd13, 8'd11, 1'b0);
        chk("t1_lat0", out_valid, 0);
        step();
        chk("t1_lat1", out_valid, 0);
        step();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 143);
        drain();

        // 2: accumulate to saturation, then a load keeps the sticky flag
        do_clr();
        for (int i = 0; i < 17; i++) send(8'd255, 8'd255, 1'b1);
        send(8'd2, 8'd3, 1'b0);
        drain();
        chk("t2_final_data", out_data, 6);
        chk("t2_final_sat", sat, 1);

        // 3: mid-stream stall of five cycles
        do_clr();
        for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
        a = 8'($urandom); b = 8'($urandom); acc_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_in_ready_stall", smp_in_ready, 0);
        end
        out_ready = 1'b1;
        send(a, b, acc_en);
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'($urandom));
        drain();

        // 4: clear coinciding with the accumulator capture
        do_clr();
        send(8'd40, 8'd25, 1'b0);
        drain();
        chk("t4_pre", out_data, 1000);
        model_acc = 0; model_sat = 1'b0;
        send(8'd4, 8'd5, 1'b1);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_data", out_data, 20);
        chk("t4_sat", sat, 0);
        drain();

        // 5: asynchronous reset with beats in flight
        for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom), 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_data", out_data, 0);
        chk("t5_rst_sat", sat, 0);
        exp_q.delete();
        model_acc = 0; model_sat = 1'b0; prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_stale", out_valid, 0);
        end
        send(8'd2, 8'd3, 1'b0);
        step();
        step();
        chk("t5_valid", out_valid, 1);
        chk("t5_data", out_data, 6);
        drain();

        // 6: random products with random backpressure, corners first
        ca = '{8'd0, 8'd255, 8'd255, 8'd1};
        cb = '{8'd255, 8'd0, 8'd255, 8'd1};
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (i < 4) send(ca[i], cb[i], 1'b0);
            else send(8'($urandom), 8'($urandom), 1'b0);
        end
        drain();

        // Mixed accumulate/load stream
        do_clr();
        for (int i = 0; i < 150; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            send(8'($urandom), 8'($urandom), ($urandom_range(0, 7) != 0));
        end
        drain();

        // WIDTH=4 exhaustive
        for (int i = 0; i < 259; i++) begin
            if (i < 256) begin
                a4 = 4'(i >> 4); b4 = 4'(i); in_valid4 = 1'b1;
            end else in_valid4 = 1'b0;
            @(negedge clk);
            if (out_valid4) begin
                if (q4.size() == 0) chk("w4_spurious", out_valid4, 0);
                else chk("w4_prod", out_data4, q4.pop_front());
            end
            @(posedge clk);
            #1;
            if (in_valid4) q4.push_back(longint'(a4) * longint'(b4));
        end
        in_valid4 = 1'b0;
        chk("w4_drain", q4.size(), 0);

        // WIDTH=16 random
        for (int i = 0; i < 103; i++) begin
            if (i < 100) begin
                a16 = 16'($urandom); b16 = 16'($urandom); in_valid16 = 1'b1;
                if (i == 0) begin a16 = 16'hffff; b16 = 16'hffff; end
            end else in_valid16 = 1'b0;
            @(negedge clk);
            if (out_valid16) begin
                if (q16.size() == 0) chk("w16_spurious", out_valid16, 0);
                else chk("w16_prod", out_data16, q16.pop_front());
            end
            @(posedge clk);
            #1;
            if (in_valid16) q16.push_back(longint'(a16) * longint'(b16));
        end
        in_valid16 = 1'b0;
        chk("w16_drain", q16.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
